// File: rtl/tx_sched.sv
// DCSK TX frame scheduler: round-robin grant of two requesters, then seed load, send and is_sending tracking.
// Registered outputs; load_seed/send follow the grant by 1/2 cycles; requests wait (ready low) until IDLE.
module tx_sched #(
  parameter int MSG_W     = 32,
  parameter int SEED_W    = 16,
  parameter int SF_W      = 5,
  parameter int GAP_CYC   = 4,
  parameter int START_TMO = 8
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [MSG_W-1:0]  i_req_msg0,
  input  logic [MSG_W-1:0]  i_req_msg1,
  input  logic [SEED_W-1:0] i_req_seed0,
  input  logic [SEED_W-1:0] i_req_seed1,
  input  logic [SF_W-1:0]   i_sf,
  output logic [MSG_W-1:0]  o_msg,
  output logic [SEED_W-1:0] o_seed,
  output logic [SF_W-1:0]   o_sf,
  output logic              o_load_seed,
  output logic              o_send,
  input  logic              i_is_sending,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_done_id,
  output logic              o_timeout
);

  localparam int TMO_W = $clog2(START_TMO + 1);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_START,
    S_ACTIVE,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               last_grant_q;
  logic [1:0]         ready_d;
  logic               load_seed_d, send_d, done_d, timeout_d, done_id_d;
  logic               take, xfer, pick;

  // Outputs are registered from the next state, so each pulse lines up with the state it names.
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = tmo_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ready_d     = 2'b00;
    load_seed_d = 1'b0;
    send_d      = 1'b0;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    done_id_d   = o_done_id;
    take        = 1'b0;
    xfer        = |(i_req_valid & o_req_ready);
    pick        = (&i_req_valid) ? ~last_grant_q : i_req_valid[1];

    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          take        = 1'b1;
          state_d     = S_LOAD;
          load_seed_d = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SEND;
        send_d  = 1'b1;
      end
      S_SEND: begin
        state_d   = S_START;
        tmo_cnt_d = '0;
      end
      S_START: begin
        if (i_is_sending) begin
          state_d = S_ACTIVE;
        end else if (tmo_cnt_q >= TMO_LAST) begin
          state_d   = S_GAP;
          timeout_d = 1'b1;
          gap_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (!i_is_sending) begin
          state_d   = S_GAP;
          done_d    = 1'b1;
          done_id_d = last_grant_q;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (GAP_CYC == 0 || gap_cnt_q >= GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A grant withdrawn before transfer simply re-arbitrates on the current requests.
    if (state_d == S_IDLE && |i_req_valid) begin
      ready_d = pick ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= S_IDLE;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      o_req_ready  <= 2'b00;
      o_msg        <= '0;
      o_seed       <= '0;
      o_sf         <= '0;
      o_load_seed  <= 1'b0;
      o_send       <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_done_id    <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      o_req_ready <= ready_d;
      o_load_seed <= load_seed_d;
      o_send      <= send_d;
      o_busy      <= (state_d != S_IDLE);
      o_done      <= done_d;
      o_done_id   <= done_id_d;
      o_timeout   <= timeout_d;
      if (take) begin
        o_msg        <= o_req_ready[1] ? i_req_msg1 : i_req_msg0;
        o_seed       <= o_req_ready[1] ? i_req_seed1 : i_req_seed0;
        o_sf         <= i_sf;
        last_grant_q <= o_req_ready[1];
      end
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// Directed bench for tx_sched: default instance (GAP_CYC=4, START_TMO=8) plus a GAP_CYC=0 instance.
module tb_tx_sched;

  logic        clk;
  logic        arst_n;
  logic [1:0]  req_valid, ready;
  logic [31:0] msg0, msg1, msg_out;
  logic [15:0] seed0, seed1, seed_out;
  logic [4:0]  sf_in, sf_out;
  logic        load_seed, send, is_sending, busy, done, done_id, timeout;

  logic [1:0]  z_valid, z_ready;
  logic [31:0] z_msg0, z_msg1, z_msg_out;
  logic [15:0] z_seed0, z_seed1, z_seed_out;
  logic [4:0]  z_sf_in, z_sf_out;
  logic        z_load_seed, z_send, z_is, z_busy, z_done, z_done_id, z_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tx_sched dut (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_req_valid(req_valid), .o_req_ready(ready),
    .i_req_msg0(msg0), .i_req_msg1(msg1),
    .i_req_seed0(seed0), .i_req_seed1(seed1),
    .i_sf(sf_in), .o_msg(msg_out), .o_seed(seed_out), .o_sf(sf_out),
    .o_load_seed(load_seed), .o_send(send), .i_is_sending(is_sending),
    .o_busy(busy), .o_done(done), .o_done_id(done_id), .o_timeout(timeout)
  );

  tx_sched #(.GAP_CYC(0)) dut0 (
    .i_clk(clk), .i_arst_n(arst_n),
    .i_req_valid(z_valid), .o_req_ready(z_ready),
    .i_req_msg0(z_msg0), .i_req_msg1(z_msg1),
    .i_req_seed0(z_seed0), .i_req_seed1(z_seed1),
    .i_sf(z_sf_in), .o_msg(z_msg_out), .o_seed(z_seed_out), .o_sf(z_sf_out),
    .o_load_seed(z_load_seed), .o_send(z_send), .i_is_sending(z_is),
    .o_busy(z_busy), .o_done(z_done), .o_done_id(z_done_id), .o_timeout(z_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 64'(ok), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g_cyc[4];
    int n_a, n_b;
    logic ok;

    arst_n = 1'b0; req_valid = 2'b00; is_sending = 1'b0;
    msg0 = '0; msg1 = '0; seed0 = '0; seed1 = '0; sf_in = '0;
    z_valid = 2'b00; z_is = 1'b0;
    z_msg0 = '0; z_msg1 = '0; z_seed0 = '0; z_seed1 = '0; z_sf_in = '0;
    tick(); tick();

    // Reset state
    chk("rst_ready", 64'(ready), 64'h0);
    chk("rst_load_seed", 64'(load_seed), 64'h0);
    chk("rst_send", 64'(send), 64'h0);
    chk("rst_msg", 64'(msg_out), 64'h0);
    chk("rst_seed", 64'(seed_out), 64'h0);
    chk("rst_sf", 64'(sf_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_done_id", 64'(done_id), 64'h0);
    chk("rst_timeout", 64'(timeout), 64'h0);
    chk("rst_z_busy", 64'(z_busy), 64'h0);
    arst_n = 1'b1;
    tick();

    // Round-robin: both requesters valid for four frames, core busy one cycle each
    msg0 = 32'hA0A0_A0A0; seed0 = 16'h1111;
    msg1 = 32'hB1B1_B1B1; seed1 = 16'h5678;
    sf_in = 5'd9;
    req_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_rdy("rr_wait_ready");
      g_cyc[f] = cyc;
      chk("rr_grant", 64'(ready), (f % 2 == 0) ? 64'h1 : 64'h2);
      if (f > 0) chk("rr_spacing", 64'(g_cyc[f] - g_cyc[f-1]), 64'd9);
      tick();
      chk("rr_ready_single", 64'(ready), 64'h0);
      chk("rr_msg", 64'(msg_out), (f % 2 == 0) ? 64'hA0A0_A0A0 : 64'hB1B1_B1B1);
      chk("rr_seed", 64'(seed_out), (f % 2 == 0) ? 64'h1111 : 64'h5678);
      tick(); tick();
      is_sending = 1'b1;
      tick();
      is_sending = 1'b0;
      tick();
      chk("rr_done", 64'(done), 64'h1);
      chk("rr_done_id", 64'(done_id), 64'(f % 2));
    end
    req_valid = 2'b00;
    repeat (4) tick();
    chk("rr_idle", 64'(busy), 64'h0);

    // Single request from requester 0
    msg0 = 32'hDEAD_BEEF; seed0 = 16'h1234; sf_in = 5'd7;
    req_valid = 2'b01;
    wait_rdy("single_wait_ready");
    chk("single_ready", 64'(ready), 64'h1);
    chk("single_busy_T", 64'(busy), 64'h0);
    tick();
    req_valid = 2'b00;
    chk("single_load_seed", 64'(load_seed), 64'h1);
    chk("single_ready_T1", 64'(ready), 64'h0);
    chk("single_send_T1", 64'(send), 64'h0);
    chk("single_msg", 64'(msg_out), 64'hDEAD_BEEF);
    chk("single_seed", 64'(seed_out), 64'h1234);
    chk("single_sf", 64'(sf_out), 64'h7);
    chk("single_busy", 64'(busy), 64'h1);
    tick();
    chk("single_send", 64'(send), 64'h1);
    chk("single_load_seed_T2", 64'(load_seed), 64'h0);
    tick();
    chk("single_send_T3", 64'(send), 64'h0);
    tick();
    is_sending = 1'b1;
    n_a = 0;
    repeat (20) begin
      tick();
      if (done) n_a++;
    end
    chk("single_no_early_done", 64'(n_a), 64'h0);
    is_sending = 1'b0;
    tick();
    chk("single_done", 64'(done), 64'h1);
    chk("single_done_id", 64'(done_id), 64'h0);
    chk("single_no_timeout", 64'(timeout), 64'h0);
    tick();
    chk("single_done_pulse", 64'(done), 64'h0);
    chk("single_gap_busy", 64'(busy), 64'h1);
    repeat (3) tick();
    chk("single_idle", 64'(busy), 64'h0);

    // Start timeout: core never raises is_sending
    req_valid = 2'b01;
    wait_rdy("tmo_wait_ready");
    tick();
    req_valid = 2'b00;
    n_a = 0; n_b = 0;
    repeat (9) begin
      tick();
      if (timeout) n_a++;
    end
    chk("tmo_not_early", 64'(n_a), 64'h0);
    tick();
    chk("tmo_pulse", 64'(timeout), 64'h1);
    if (done) n_b++;
    tick();
    chk("tmo_pulse_single", 64'(timeout), 64'h0);
    if (done) n_b++;
    repeat (2) begin
      tick();
      if (done) n_b++;
    end
    chk("tmo_gap_busy", 64'(busy), 64'h1);
    tick();
    if (done) n_b++;
    chk("tmo_idle", 64'(busy), 64'h0);
    chk("tmo_no_done", 64'(n_b), 64'h0);

    // Timeout race: is_sending rises on the last START cycle
    msg1 = 32'h7777_0001; req_valid = 2'b10;
    wait_rdy("race_wait_ready");
    chk("race_grant", 64'(ready), 64'h2);
    tick();
    req_valid = 2'b00;
    n_a = 0;
    repeat (9) begin
      tick();
      if (timeout) n_a++;
    end
    is_sending = 1'b1;
    tick();
    if (timeout) n_a++;
    chk("race_no_timeout", 64'(n_a), 64'h0);
    chk("race_active_busy", 64'(busy), 64'h1);
    is_sending = 1'b0;
    tick();
    chk("race_done", 64'(done), 64'h1);
    chk("race_done_id", 64'(done_id), 64'h1);
    chk("race_timeout_at_done", 64'(timeout), 64'h0);
    repeat (4) tick();
    chk("race_idle", 64'(busy), 64'h0);

    // Asynchronous reset in the middle of ACTIVE
    msg0 = 32'h1357_9BDF; seed0 = 16'h2468; sf_in = 5'd3;
    req_valid = 2'b01;
    wait_rdy("arst_wait_ready");
    tick();
    req_valid = 2'b00;
    tick(); tick();
    is_sending = 1'b1;
    tick(); tick();
    chk("arst_pre_busy", 64'(busy), 64'h1);
    chk("arst_pre_msg", 64'(msg_out), 64'h1357_9BDF);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_msg", 64'(msg_out), 64'h0);
    chk("arst_seed", 64'(seed_out), 64'h0);
    chk("arst_sf", 64'(sf_out), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done_id", 64'(done_id), 64'h0);
    is_sending = 1'b0;
    tick(); tick();
    arst_n = 1'b1;
    n_a = 0;
    repeat (3) begin
      tick();
      if (done || timeout) n_a++;
    end
    chk("arst_no_done_timeout", 64'(n_a), 64'h0);
    msg1 = 32'hCAFE_F00D;
    req_valid = 2'b10;
    wait_rdy("arst_req1_wait_ready");
    chk("arst_req1_grant", 64'(ready), 64'h2);
    tick();
    req_valid = 2'b00;
    chk("arst_req1_msg", 64'(msg_out), 64'hCAFE_F00D);
    tick(); tick();
    is_sending = 1'b1;
    tick();
    is_sending = 1'b0;
    tick();
    chk("arst_req1_done", 64'(done), 64'h1);
    chk("arst_req1_done_id", 64'(done_id), 64'h1);
    repeat (4) tick();

    // GAP_CYC=0 instance: valid held into the frame then withdrawn in ACTIVE
    z_msg0 = 32'h0BAD_CAFE; z_seed0 = 16'h00FF; z_sf_in = 5'd31;
    z_valid = 2'b01;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (z_ready != 2'b00) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("z_wait_ready", 64'(ok), 64'h1);
    chk("z_grant", 64'(z_ready), 64'h1);
    tick();
    chk("z_ready_single", 64'(z_ready), 64'h0);
    chk("z_load_seed", 64'(z_load_seed), 64'h1);
    chk("z_msg", 64'(z_msg_out), 64'h0BAD_CAFE);
    n_a = 0;
    tick();
    if (z_ready != 2'b00) n_a++;
    tick();
    if (z_ready != 2'b00) n_a++;
    z_is = 1'b1;
    tick();
    if (z_ready != 2'b00) n_a++;
    z_valid = 2'b00;
    tick();
    if (z_ready != 2'b00) n_a++;
    chk("z_ready_held_off", 64'(n_a), 64'h0);
    z_is = 1'b0;
    tick();
    chk("z_done", 64'(z_done), 64'h1);
    chk("z_done_id", 64'(z_done_id), 64'h0);
    chk("z_gap_busy", 64'(z_busy), 64'h1);
    tick();
    chk("z_idle", 64'(z_busy), 64'h0);
    chk("z_done_pulse", 64'(z_done), 64'h0);
    n_a = 0;
    repeat (8) begin
      tick();
      if (z_ready != 2'b00) n_a++;
    end
    chk("z_no_regrant", 64'(n_a), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
